// File: rtl/pipe_pkg.sv
// Shared opcodes, forwarding-select encoding and hazard FSM states for the 5-stage pipeline.
package pipe_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_MM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; EX/MM beats MM/WB, loads only from MM/WB.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src_reg_i,
  input  logic       ex_mm_wr_en_i,
  input  logic [4:0] ex_mm_wr_num_i,
  input  logic       ex_mm_is_load_i,
  input  logic       mm_wb_wr_en_i,
  input  logic [4:0] mm_wb_wr_num_i,
  output logic [1:0] sel_o
);

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_RF;
    if (ex_mm_wr_en_i && (ex_mm_wr_num_i != 5'd0) && (ex_mm_wr_num_i == src_reg_i) &&
        !ex_mm_is_load_i) begin
      sel = FWD_MM;
    end else if (mm_wb_wr_en_i && (mm_wb_wr_num_i != 5'd0) && (mm_wb_wr_num_i == src_reg_i)) begin
      sel = FWD_WB;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, memory-wait timeout FSM, forwarding, counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic [5:0]       opcode_id_ex,
  input  logic [4:0]       wr_num_id_ex,
  input  logic             wr_en_reg_id_ex,
  input  logic [4:0]       rs_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic             branch_taken_ex,
  input  logic [5:0]       opcode_ex_mm,
  input  logic [4:0]       wr_num_ex_mm,
  input  logic             wr_en_reg_ex_mm,
  input  logic [4:0]       wr_num_mm_wb,
  input  logic             wr_en_reg_mm_wb,
  input  logic             mem_ready,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mm,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_mm_wb,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

  hz_state_t        state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_op, mem_stall, load_use, is_load_mm;
  logic stall_inc, flush_inc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign is_load_mm = (opcode_ex_mm == OP_LW);
  assign mem_op     = is_load_mm || (opcode_ex_mm == OP_SW);
  assign mem_stall  = mem_op && !mem_ready;
  assign load_use   = (opcode_id_ex == OP_LW) && wr_en_reg_id_ex && (wr_num_id_ex != 5'd0) &&
                      ((wr_num_id_ex == rs_if_id) || (wr_num_id_ex == rt_if_id));

  always_comb begin
    en_pc        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mm     = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    bubble_mm_wb = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mm} = 4'b0000;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      bubble_mm_wb = 1'b1;
    end else if (state_q == HALT) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mm} = 4'b0000;
      bubble_mm_wb = 1'b1;
      halted       = 1'b1;
    end else if (mem_stall) begin
      // Whole front end freezes; a taken branch in EX is held until the access completes.
      {en_pc, en_if_id, en_id_ex, en_ex_mm} = 4'b0000;
      bubble_mm_wb = 1'b1;
      stall_inc    = 1'b1;
    end else if (branch_taken_ex) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      en_pc       = 1'b0;
      en_if_id    = 1'b0;
      flush_id_ex = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          if (MEM_TIMEOUT == 1) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = 16'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wait_d  = 16'd0;
        end else if (wait_q == TimeoutLast) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wait_d  = 16'd0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush_inc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  fwd_unit u_fwd_a (
    .src_reg_i       (rs_id_ex),
    .ex_mm_wr_en_i   (wr_en_reg_ex_mm),
    .ex_mm_wr_num_i  (wr_num_ex_mm),
    .ex_mm_is_load_i (is_load_mm),
    .mm_wb_wr_en_i   (wr_en_reg_mm_wb),
    .mm_wb_wr_num_i  (wr_num_mm_wb),
    .sel_o           (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src_reg_i       (rt_id_ex),
    .ex_mm_wr_en_i   (wr_en_reg_ex_mm),
    .ex_mm_wr_num_i  (wr_num_ex_mm),
    .ex_mm_is_load_i (is_load_mm),
    .mm_wb_wr_en_i   (wr_en_reg_mm_wb),
    .mm_wb_wr_num_i  (wr_num_mm_wb),
    .sel_o           (fwd_b_raw)
  );

  assign fwd_a_sel = rst ? 2'b00 : fwd_a_raw;
  assign fwd_b_sel = rst ? 2'b00 : fwd_b_raw;
  assign mem_err   = err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan scenarios plus randomized traffic.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned T    = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs_if_id, rt_if_id, wr_num_id_ex, rs_id_ex, rt_id_ex, wr_num_ex_mm, wr_num_mm_wb;
  logic [5:0] opcode_id_ex, opcode_ex_mm;
  logic wr_en_reg_id_ex, branch_taken_ex, wr_en_reg_ex_mm, wr_en_reg_mm_wb, mem_ready;
  logic en_pc, en_if_id, en_id_ex, en_ex_mm, flush_if_id, flush_id_ex, bubble_mm_wb;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
    .opcode_id_ex(opcode_id_ex), .wr_num_id_ex(wr_num_id_ex), .wr_en_reg_id_ex(wr_en_reg_id_ex),
    .rs_id_ex(rs_id_ex), .rt_id_ex(rt_id_ex), .branch_taken_ex(branch_taken_ex),
    .opcode_ex_mm(opcode_ex_mm), .wr_num_ex_mm(wr_num_ex_mm), .wr_en_reg_ex_mm(wr_en_reg_ex_mm),
    .wr_num_mm_wb(wr_num_mm_wb), .wr_en_reg_mm_wb(wr_en_reg_mm_wb), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mm(en_ex_mm),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .bubble_mm_wb(bubble_mm_wb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [7:0]  ctl;  // {en_pc, en_if_id, en_id_ex, en_ex_mm, flush_if, flush_id, bubble, halted}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        err;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: consecutive memory-stall cycles, halt/error flags, event counts.
  int unsigned m_run = 0, m_sc = 0, m_fc = 0;
  bit m_halt = 0, m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (wr_en_reg_ex_mm && wr_num_ex_mm != 0 && wr_num_ex_mm == src && opcode_ex_mm != OP_LW)
      return 2'b10;
    if (wr_en_reg_mm_wb && wr_num_mm_wb != 0 && wr_num_mm_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    exp_t e;
    bit ms, lu;
    ms = (opcode_ex_mm == OP_LW || opcode_ex_mm == OP_SW) && !mem_ready;
    lu = opcode_id_ex == OP_LW && wr_en_reg_id_ex && wr_num_id_ex != 0 &&
         (wr_num_id_ex == rs_if_id || wr_num_id_ex == rt_if_id);
    if (rst) begin
      m_run = 0; m_sc = 0; m_fc = 0; m_halt = 0; m_err = 0;
      e.ctl = 8'b0000_1110;
    end else if (m_halt) e.ctl = 8'b0000_0011;
    else if (ms)         e.ctl = 8'b0000_0010;
    else if (branch_taken_ex) e.ctl = 8'b1111_1100;
    else if (lu)         e.ctl = 8'b0011_0100;
    else                 e.ctl = 8'b1111_0000;
    e.fa  = rst ? 2'b00 : fwd_ref(rs_id_ex);
    e.fb  = rst ? 2'b00 : fwd_ref(rt_id_ex);
    e.err = m_err;
    e.sc  = m_sc;
    e.fc  = m_fc;
    q.push_back(e);
    if (!rst && !m_halt) begin
      if (ms) begin
        m_run++;
        if (m_sc < CMAX) m_sc++;
        if (m_run == T) begin m_halt = 1; m_err = 1; end
      end else begin
        m_run = 0;
        if (branch_taken_ex) begin if (m_fc < CMAX) m_fc++; end
        else if (lu) begin if (m_sc < CMAX) m_sc++; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl", {en_pc, en_if_id, en_id_ex, en_ex_mm, flush_if_id, flush_id_ex, bubble_mm_wb,
                  halted}, e.ctl);
      chk("fwd_a", fwd_a_sel, e.fa);
      chk("fwd_b", fwd_b_sel, e.fb);
      chk("mem_err", mem_err, e.err);
      chk("stall_cnt", stall_cnt, e.sc[CW-1:0]);
      chk("flush_cnt", flush_cnt, e.fc[CW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neutral();
    {rs_if_id, rt_if_id, wr_num_id_ex, rs_id_ex, rt_id_ex, wr_num_ex_mm, wr_num_mm_wb} = '0;
    opcode_id_ex = 6'h00; opcode_ex_mm = 6'h00;
    {wr_en_reg_id_ex, branch_taken_ex, wr_en_reg_ex_mm, wr_en_reg_mm_wb} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; neutral(); step();
    tick(); step();
    tick(); rst = 1'b0; step();
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 3))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_BEQ;
      default: return 6'h00;
    endcase
  endfunction

  initial begin
    neutral();
    do_reset();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_halted", halted, 0);

    // Load-use: exactly one stall cycle.
    tick(); opcode_id_ex = OP_LW; wr_en_reg_id_ex = 1; wr_num_id_ex = 5; rs_if_id = 5; step();
    #1 chk("lu_en_pc", en_pc, 0);
    tick(); neutral(); step();
    tick(); chk("lu_stall_cnt", stall_cnt, 1);
    step();

    // Load into r0 never stalls.
    tick(); opcode_id_ex = OP_LW; wr_en_reg_id_ex = 1; wr_num_id_ex = 0; rs_if_id = 0; step();
    #1 chk("r0_en_pc", en_pc, 1);
    chk("r0_fwd_a", fwd_a_sel, 0);

    // Taken branch overrides load-use.
    do_reset();
    tick(); opcode_id_ex = OP_LW; wr_en_reg_id_ex = 1; wr_num_id_ex = 5; rs_if_id = 5;
    branch_taken_ex = 1; step();
    #1 chk("br_lu_flush", {en_pc, flush_if_id, flush_id_ex}, 3'b111);
    tick(); neutral(); step();
    #1 chk("br_lu_flush_cnt", flush_cnt, 1);
    chk("br_lu_stall_cnt", stall_cnt, 0);

    // Three-cycle memory wait with a held branch.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(); opcode_ex_mm = OP_LW; mem_ready = 0; branch_taken_ex = 1; step();
    end
    tick(); mem_ready = 1; step();
    #1 chk("mw_flush_after", flush_if_id, 1);
    tick(); neutral(); step();
    #1 chk("mw_stall_cnt", stall_cnt, 3);
    chk("mw_flush_cnt", flush_cnt, 1);
    chk("mw_not_halted", halted, 0);

    // Timeout to HALT after T stall cycles.
    do_reset();
    for (int i = 0; i < T + 2; i++) begin
      tick(); opcode_ex_mm = OP_SW; mem_ready = 0; step();
    end
    #1 chk("to_halted", halted, 1);
    chk("to_mem_err", mem_err, 1);
    chk("to_stall_cnt", stall_cnt, T);
    do_reset();
    #1 chk("to_rst_halted", halted, 0);
    chk("to_rst_mem_err", mem_err, 0);

    // Forwarding priority.
    tick(); rs_id_ex = 7; wr_en_reg_ex_mm = 1; wr_num_ex_mm = 7; wr_en_reg_mm_wb = 1;
    wr_num_mm_wb = 7; step();
    #1 chk("fwd_mm", fwd_a_sel, 2'b10);
    tick(); opcode_ex_mm = OP_LW; step();
    #1 chk("fwd_load_wb", fwd_a_sel, 2'b01);
    tick(); rt_id_ex = 0; wr_num_ex_mm = 0; wr_num_mm_wb = 0; step();
    #1 chk("fwd_r0", fwd_b_sel, 2'b00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      tick();
      rst = ($urandom_range(0, 49) == 0);
      rs_if_id = 5'($urandom_range(0, 3)); rt_if_id = 5'($urandom_range(0, 3));
      wr_num_id_ex = 5'($urandom_range(0, 3)); rs_id_ex = 5'($urandom_range(0, 3));
      rt_id_ex = 5'($urandom_range(0, 3)); wr_num_ex_mm = 5'($urandom_range(0, 3));
      wr_num_mm_wb = 5'($urandom_range(0, 3));
      opcode_id_ex = rand_op(); opcode_ex_mm = rand_op();
      wr_en_reg_id_ex = 1'($urandom); wr_en_reg_ex_mm = 1'($urandom);
      wr_en_reg_mm_wb = 1'($urandom);
      branch_taken_ex = ($urandom_range(0, 5) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1 chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
